// File: rtl/axi_dram_if.sv
// AXI4 bus bundle for the ISP 128-bit DRAM port (*_s_inf signal family).
// Modports:
//   slave  - the memory responder (axi_dram_slave)
//   master - the requester (ISP core or testbench)
// Channels: AW/W/B (write burst, data, response), AR/R (read burst, data).
interface axi_dram_if;
    logic [3:0]   awid_s_inf;
    logic [31:0]  awaddr_s_inf;
    logic [2:0]   awsize_s_inf;
    logic [1:0]   awburst_s_inf;
    logic [7:0]   awlen_s_inf;
    logic         awvalid_s_inf;
    logic         awready_s_inf;
    logic [127:0] wdata_s_inf;
    logic         wlast_s_inf;
    logic         wvalid_s_inf;
    logic         wready_s_inf;
    logic [3:0]   bid_s_inf;
    logic [1:0]   bresp_s_inf;
    logic         bvalid_s_inf;
    logic         bready_s_inf;
    logic [3:0]   arid_s_inf;
    logic [31:0]  araddr_s_inf;
    logic [7:0]   arlen_s_inf;
    logic [2:0]   arsize_s_inf;
    logic [1:0]   arburst_s_inf;
    logic         arvalid_s_inf;
    logic         arready_s_inf;
    logic [3:0]   rid_s_inf;
    logic [127:0] rdata_s_inf;
    logic [1:0]   rresp_s_inf;
    logic         rlast_s_inf;
    logic         rvalid_s_inf;
    logic         rready_s_inf;

    modport slave (
        input  awid_s_inf, awaddr_s_inf, awsize_s_inf, awburst_s_inf, awlen_s_inf, awvalid_s_inf,
        output awready_s_inf,
        input  wdata_s_inf, wlast_s_inf, wvalid_s_inf,
        output wready_s_inf,
        output bid_s_inf, bresp_s_inf, bvalid_s_inf,
        input  bready_s_inf,
        input  arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf, arburst_s_inf, arvalid_s_inf,
        output arready_s_inf,
        output rid_s_inf, rdata_s_inf, rresp_s_inf, rlast_s_inf, rvalid_s_inf,
        input  rready_s_inf
    );

    modport master (
        output awid_s_inf, awaddr_s_inf, awsize_s_inf, awburst_s_inf, awlen_s_inf, awvalid_s_inf,
        input  awready_s_inf,
        output wdata_s_inf, wlast_s_inf, wvalid_s_inf,
        input  wready_s_inf,
        input  bid_s_inf, bresp_s_inf, bvalid_s_inf,
        output bready_s_inf,
        output arid_s_inf, araddr_s_inf, arlen_s_inf, arsize_s_inf, arburst_s_inf, arvalid_s_inf,
        input  arready_s_inf,
        input  rid_s_inf, rdata_s_inf, rresp_s_inf, rlast_s_inf, rvalid_s_inf,
        output rready_s_inf
    );
endinterface

// File: rtl/axi_dram_slave.sv
// AXI4 memory responder for the ISP 128-bit DRAM port. Accepts INCR read and
// write bursts (one outstanding per channel, channels independent) against an
// internal DEPTH x 128-bit word array. Every beat is 16 bytes; size, burst
// type and address bits [3:0] are ignored.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (aborts any burst in flight)
//   s     - axi_dram_if.slave bus (AW/W/B write channels, AR/R read channels)
// Parameters: ADDR_BASE (byte address of word 0), DEPTH (words),
//   RD_LAT (idle cycles between AR handshake and first rvalid, 0..15).
// Optional feature: define AXI_SLV_ADDR_CHECK_EN to range-check bursts and
//   answer out-of-range ones with SLVERR (writes dropped, reads return 0).
//   Without it, word indices wrap modulo DEPTH and responses are OKAY.
// All outputs come straight from flops.
module axi_dram_slave #(
    parameter logic [31:0] ADDR_BASE = 32'h0001_0000,
    parameter int          DEPTH     = 3072,
    parameter int          RD_LAT    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_dram_if.slave  s
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    function automatic idx_t start_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - ADDR_BASE) >> 4;
        return idx_t'(off % 32'(DEPTH));
    endfunction

    function automatic idx_t next_idx(input idx_t i);
        return (i == idx_t'(DEPTH - 1)) ? '0 : idx_t'(i + 1'b1);
    endfunction

    logic aw_oor, ar_oor;
`ifdef AXI_SLV_ADDR_CHECK_EN
    function automatic logic out_of_range(input logic [31:0] addr, input logic [7:0] len);
        logic [32:0] last_word;
        last_word = 33'((addr - ADDR_BASE) >> 4) + 33'(len);
        return (addr < ADDR_BASE) || (last_word >= 33'(DEPTH));
    endfunction
    assign aw_oor = out_of_range(s.awaddr_s_inf, s.awlen_s_inf);
    assign ar_oor = out_of_range(s.araddr_s_inf, s.arlen_s_inf);
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{s.awsize_s_inf, s.awburst_s_inf, s.arsize_s_inf,
                         s.arburst_s_inf, s.wlast_s_inf};

    logic [127:0] mem [DEPTH];

    // ---------------- write channel ----------------
    w_state_e    w_state_q, w_state_d;
    logic [3:0]  wid_q, wid_d;
    idx_t        widx_q, widx_d;
    logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic        werr_q, werr_d;
    logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [3:0]  bid_q, bid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        mem_we;

    always_comb begin
        w_state_d = w_state_q;
        wid_d     = wid_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: if (s.awvalid_s_inf && awready_q) begin
                wid_d     = s.awid_s_inf;
                widx_d    = start_idx(s.awaddr_s_inf);
                wlen_d    = s.awlen_s_inf;
                wcnt_d    = '0;
                werr_d    = aw_oor;
                w_state_d = W_DATA;
            end
            W_DATA: if (s.wvalid_s_inf && wready_q) begin
                // Out-of-range bursts still consume every beat, just drop it.
                mem_we = !werr_q;
                widx_d = next_idx(widx_q);
                wcnt_d = 8'(wcnt_q + 8'd1);
                // Beat count, not wlast, terminates the burst.
                if (wcnt_q == wlen_q) begin
                    w_state_d = W_RESP;
                    bid_d     = wid_q;
                    bresp_d   = werr_q ? SLVERR : OKAY;
                end
            end
            W_RESP: if (s.bready_s_inf && bvalid_q) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        // Handshake outputs follow the next state so they are registered.
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // ---------------- read channel ----------------
    r_state_e     r_state_q, r_state_d;
    logic [3:0]   rtag_q, rtag_d;
    idx_t         ridx_q, ridx_d;
    logic [7:0]   rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic         rerr_q, rerr_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic         arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [3:0]   rid_q, rid_d;
    logic [1:0]   rresp_q, rresp_d;
    logic [127:0] rdata_q, rdata_d;
    logic         rd_load;

    always_comb begin
        r_state_d = r_state_q;
        rtag_d    = rtag_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rerr_d    = rerr_q;
        lat_d     = lat_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rd_load   = 1'b0;
        case (r_state_q)
            R_IDLE: if (s.arvalid_s_inf && arready_q) begin
                rtag_d = s.arid_s_inf;
                ridx_d = start_idx(s.araddr_s_inf);
                rlen_d = s.arlen_s_inf;
                rcnt_d = '0;
                rerr_d = ar_oor;
                lat_d  = '0;
                if (RD_LAT == 0) begin
                    r_state_d = R_DATA;
                    rd_load   = 1'b1;
                end else begin
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: if (lat_q == CNT_W'(RD_LAT - 1)) begin
                r_state_d = R_DATA;
                rd_load   = 1'b1;
            end else begin
                lat_d = CNT_W'(lat_q + 1'b1);
            end
            R_DATA: if (rvalid_q && s.rready_s_inf) begin
                if (rcnt_q == rlen_q) begin
                    r_state_d = R_IDLE;
                    rlast_d   = 1'b0;
                end else begin
                    ridx_d  = next_idx(ridx_q);
                    rcnt_d  = 8'(rcnt_q + 8'd1);
                    rd_load = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // A beat is fetched one edge before it is presented. If the same word
        // is written on that edge, forward the write so the presented beat
        // already reflects it; the beat on the bus during the write keeps
        // the old value because rdata is only reloaded on a handshake.
        if (rd_load) begin
            if (rerr_d)
                rdata_d = '0;
            else if (mem_we && (widx_q == ridx_d))
                rdata_d = s.wdata_s_inf;
            else
                rdata_d = mem[ridx_d];
            rlast_d = (rcnt_d == rlen_d);
            rid_d   = rtag_d;
            rresp_d = rerr_d ? SLVERR : OKAY;
        end
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            rtag_q    <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rerr_q    <= 1'b0;
            lat_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rtag_q    <= rtag_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rerr_q    <= rerr_d;
            lat_q     <= lat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[widx_q] <= s.wdata_s_inf;
    end

    assign s.awready_s_inf = awready_q;
    assign s.wready_s_inf  = wready_q;
    assign s.bvalid_s_inf  = bvalid_q;
    assign s.bid_s_inf     = bid_q;
    assign s.bresp_s_inf   = bresp_q;
    assign s.arready_s_inf = arready_q;
    assign s.rvalid_s_inf  = rvalid_q;
    assign s.rid_s_inf     = rid_q;
    assign s.rdata_s_inf   = rdata_q;
    assign s.rresp_s_inf   = rresp_q;
    assign s.rlast_s_inf   = rlast_q;
endmodule

// File: tb/tb_axi_dram_slave.sv
module tb_axi_dram_slave;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int          DEPTH  = 3072;
    localparam int          RD_LAT = 2;
    localparam logic [31:0] LAST_W = BASE + 32'((DEPTH - 1) * 16);

    logic clk, rst_n;
    axi_dram_if bus();

    axi_dram_slave #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .s(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic         l;
        logic [3:0]   id;
        logic [1:0]   resp;
    } rexp_t;
    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    int n_checks = 0;
    int n_pass   = 0;
    logic rr_toggle = 1'b0;

    function automatic logic [127:0] pat(input logic [31:0] seed, input int i);
        return {seed, 64'h0, 32'(i)};
    endfunction

    task automatic chk(input string nm, input logic [139:0] act, input logic [139:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------- stimulus tasks (entered and left at posedge+1) ----------
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input int len, input logic err);
        int n;
        bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        bus.awid_s_inf = id; bus.awaddr_s_inf = addr; bus.awlen_s_inf = 8'(len);
        bus.awsize_s_inf = 3'b100; bus.awburst_s_inf = 2'b01; bus.awvalid_s_inf = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.awready_s_inf && n < 400) begin @(negedge clk); n++; end
        chk("awready_wait", bus.awready_s_inf, 1);
        @(posedge clk); #1;
        bus.awvalid_s_inf = 1'b0;
        @(negedge clk);
        chk("wready_after_aw", bus.wready_s_inf, 1);
        @(posedge clk); #1;
    endtask

    task automatic w_send(input logic [31:0] seed, input int nb);
        int n;
        for (int i = 0; i < nb; i++) begin
            bus.wvalid_s_inf = 1'b1;
            bus.wdata_s_inf  = pat(seed, i);
            bus.wlast_s_inf  = (i == nb - 1);
            n = 0;
            @(negedge clk);
            while (!bus.wready_s_inf && n < 50) begin @(negedge clk); n++; end
            if (!bus.wready_s_inf) chk("wready_wait", bus.wready_s_inf, 1);
            @(posedge clk); #1;
        end
        bus.wvalid_s_inf = 1'b0;
        bus.wlast_s_inf  = 1'b0;
        @(negedge clk);
        chk("bvalid_after_last_w", bus.bvalid_s_inf, 1);
        @(posedge clk); #1;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [31:0] seed, input int first, input logic err);
        int n;
        for (int i = 0; i <= len; i++)
            rq.push_back('{d: err ? 128'h0 : pat(seed, first + i), l: (i == len),
                           id: id, resp: err ? 2'b10 : 2'b00});
        bus.arid_s_inf = id; bus.araddr_s_inf = addr; bus.arlen_s_inf = 8'(len);
        bus.arsize_s_inf = 3'b100; bus.arburst_s_inf = 2'b01; bus.arvalid_s_inf = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.arready_s_inf && n < 400) begin @(negedge clk); n++; end
        chk("arready_wait", bus.arready_s_inf, 1);
        @(posedge clk); #1;
        bus.arvalid_s_inf = 1'b0;
        // count cycles from the AR handshake edge to the first rvalid
        n = 1;
        @(negedge clk);
        while (!bus.rvalid_s_inf && n < 50) begin @(negedge clk); n++; end
        chk("r_first_latency", n, RD_LAT + 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 2000) begin @(posedge clk); n++; end
        #1;
        chk("queues_drained", {rq.size() == 0, bq.size() == 0}, 2'b11);
    endtask

    // ---------- rready driver ----------
    initial begin
        bus.rready_s_inf = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.rready_s_inf = rr_toggle ? ~bus.rready_s_inf : 1'b1;
        end
    end

    // ---------- monitor / scoreboard ----------
    initial begin
        logic pv, pr, pl;
        logic [3:0] pid;
        logic [127:0] pd;
        rexp_t re;
        bexp_t be;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pid = '0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv && !pr)
                    chk("r_hold_while_stalled",
                        {bus.rvalid_s_inf, bus.rlast_s_inf, bus.rid_s_inf, bus.rdata_s_inf},
                        {1'b1, pl, pid, pd});
                if (bus.rvalid_s_inf && bus.rready_s_inf) begin
                    if (rq.size() == 0) begin
                        n_checks++;
                        $display("FAIL r_unexpected: beat rdata %h with no beat expected", bus.rdata_s_inf);
                    end else begin
                        re = rq.pop_front();
                        chk("r_beat", {bus.rdata_s_inf, bus.rlast_s_inf, bus.rid_s_inf, bus.rresp_s_inf}, re);
                    end
                end
                if (bus.bvalid_s_inf && bus.bready_s_inf) begin
                    if (bq.size() == 0) begin
                        n_checks++;
                        $display("FAIL b_unexpected: bid %h bresp %h with no response expected",
                                 bus.bid_s_inf, bus.bresp_s_inf);
                    end else begin
                        be = bq.pop_front();
                        chk("b_resp", {bus.bid_s_inf, bus.bresp_s_inf}, be);
                    end
                end
            end
            pv = bus.rvalid_s_inf; pr = bus.rready_s_inf; pl = bus.rlast_s_inf;
            pid = bus.rid_s_inf; pd = bus.rdata_s_inf;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------- main sequence ----------
    initial begin
        rst_n = 1'b0;
        bus.awid_s_inf = '0; bus.awaddr_s_inf = '0; bus.awsize_s_inf = '0; bus.awburst_s_inf = '0;
        bus.awlen_s_inf = '0; bus.awvalid_s_inf = 1'b0; bus.wdata_s_inf = '0; bus.wlast_s_inf = 1'b0;
        bus.wvalid_s_inf = 1'b0; bus.bready_s_inf = 1'b1; bus.arid_s_inf = '0; bus.araddr_s_inf = '0;
        bus.arlen_s_inf = '0; bus.arsize_s_inf = '0; bus.arburst_s_inf = '0; bus.arvalid_s_inf = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl_outs",
            {bus.awready_s_inf, bus.wready_s_inf, bus.bvalid_s_inf, bus.bid_s_inf, bus.bresp_s_inf,
             bus.arready_s_inf, bus.rvalid_s_inf, bus.rid_s_inf, bus.rresp_s_inf, bus.rlast_s_inf}, 0);
        chk("reset_rdata", bus.rdata_s_inf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_first_edge", {bus.awready_s_inf, bus.arready_s_inf}, 2'b00);
        @(posedge clk); #1;
        chk("ready_after_first_edge", {bus.awready_s_inf, bus.arready_s_inf}, 2'b11);

        // pic 5 write, data = beat number, then read back
        aw_send(4'h5, BASE + 32'(DEPTH * 5), 191, 1'b0);
        w_send(32'h0, 192);
        drain();
        ar_send(4'h3, BASE + 32'(DEPTH * 5), 191, 32'h0, 0, 1'b0);
        drain();

        // same read with rready toggling
        rr_toggle = 1'b1;
        ar_send(4'h9, BASE + 32'(DEPTH * 5), 191, 32'h0, 0, 1'b0);
        drain();
        rr_toggle = 1'b0;
        @(posedge clk); #1;

        // pic 0: seed old data, then read old while writing new, then re-read
        aw_send(4'h1, BASE, 191, 1'b0);
        w_send(32'hAAAA_0001, 192);
        drain();
        ar_send(4'h2, BASE, 191, 32'hAAAA_0001, 0, 1'b0);
        aw_send(4'h4, BASE, 191, 1'b0);
        w_send(32'hBBBB_0002, 192);
        drain();
        ar_send(4'h6, BASE, 191, 32'hBBBB_0002, 0, 1'b0);
        drain();

`ifdef AXI_SLV_ADDR_CHECK_EN
        // known contents at the last word and word 0
        aw_send(4'h7, LAST_W, 0, 1'b0);
        w_send(32'hCCCC_0004, 1);
        aw_send(4'h8, BASE, 0, 1'b0);
        w_send(32'hCCCC_0005, 1);
        drain();
        // burst crossing the end: rejected, nothing written
        aw_send(4'hA, LAST_W, 1, 1'b1);
        w_send(32'hDDDD_0006, 2);
        drain();
        ar_send(4'hB, LAST_W, 0, 32'hCCCC_0004, 0, 1'b0);
        ar_send(4'hC, BASE, 0, 32'hCCCC_0005, 0, 1'b0);
        drain();
        // below the base address
        ar_send(4'hD, BASE - 32'd16, 0, 32'h0, 0, 1'b1);
        drain();
`else
        // burst crossing the end wraps to word 0
        aw_send(4'hA, LAST_W, 1, 1'b0);
        w_send(32'hDDDD_0006, 2);
        drain();
        ar_send(4'hB, LAST_W, 1, 32'hDDDD_0006, 0, 1'b0);
        ar_send(4'hC, BASE, 0, 32'hDDDD_0006, 1, 1'b0);
        drain();
`endif

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
